dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the MEM stage (priority,
// single-cycle) and a valid/ready loader port, with a starvation-forced loader slot.
module dmem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_stall_o,
    input  logic        ld_valid_i,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    output logic        ld_ready_o,
    output logic        ld_rvalid_o,
    output logic [31:0] ld_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_data_i,
    output logic        err_o,
    input  logic        err_clr_i
);
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [32:0] ADDR_LIM   = (33'd1 << ADDR_W) - 33'd3;

    logic [3:0]  starve_q, starve_d;
    logic        err_q, err_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic forced, core_gnt, ld_gnt, any_gnt, legal;
    req_t core_req, ld_req, sel;

    assign core_req = '{we: core_we_i, addr: core_addr_i, wdata: core_wdata_i};
    assign ld_req   = '{we: ld_we_i,   addr: ld_addr_i,   wdata: ld_wdata_i};

    // Grant terms are reset-agnostic so they can feed state; outputs are gated below.
    assign forced   = ld_valid_i && (starve_q == STARVE_LIM);
    assign core_gnt = core_req_i && !forced;
    assign ld_gnt   = ld_valid_i && (forced || !core_req_i);
    assign any_gnt  = core_gnt || ld_gnt;
    assign sel      = ld_gnt ? ld_req : core_req;
    assign legal    = (sel.addr[1:0] == 2'b00) && ({1'b0, sel.addr} < ADDR_LIM);

    always_comb begin
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        core_rdata_o = '0;
        ld_ready_o   = 1'b0;
        core_stall_o = 1'b0;
        if (rst_n) begin
            ld_ready_o   = ld_gnt;
            core_stall_o = forced && core_req_i;
            if (any_gnt && legal) begin
                mem_addr_o  = sel.addr;
                mem_data_o  = sel.wdata;
                mem_write_o = sel.we;
                mem_read_o  = !sel.we;
            end
            if (core_gnt && legal && !core_we_i)
                core_rdata_o = mem_data_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!ld_valid_i || ld_gnt)
            starve_d = '0;
        else if (starve_q < STARVE_LIM)
            starve_d = starve_q + 4'd1;
    end

    // A fresh error wins over a same-cycle clear.
    assign err_d    = (any_gnt && !legal) ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    assign rvalid_d = ld_gnt && !ld_we_i;
    assign rdata_d  = rvalid_d ? (legal ? mem_data_i : 32'h0) : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign err_o       = err_q;
    assign ld_rvalid_o = rvalid_q;
    assign ld_rdata_o  = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;
    localparam logic [31:0] LIM = 32'((1 << ADDR_W) - 3);

    logic        clk, rst_n;
    logic        core_req, core_we, ld_valid, ld_we, err_clr;
    logic [31:0] core_addr, core_wdata, ld_addr, ld_wdata;
    logic [31:0] core_rdata_o, ld_rdata_o, mem_addr_o, mem_data_o, mem_rdata;
    logic        core_stall_o, ld_ready_o, ld_rvalid_o, mem_write_o, mem_read_o, err_o;

    int n_chk = 0;
    int n_pass = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
        .ld_valid_i(ld_valid), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_ready_o(ld_ready_o), .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_o(mem_write_o),
        .mem_read_o(mem_read_o), .mem_data_i(mem_rdata), .err_o(err_o), .err_clr_i(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    logic [31:0] tb_mem [8] = '{default: 32'h0};
    assign mem_rdata = tb_mem[mem_addr_o[ADDR_W-1:2]];
    always @(posedge clk) if (mem_write_o) tb_mem[mem_addr_o[ADDR_W-1:2]] <= mem_data_o;

    // Loader protocol: valid may not drop while still waiting for ready.
    logic pend_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 1'b0;
        else begin
            if (pend_q) assert (ld_valid) else $error("loader valid withdrawn before ready");
            pend_q <= ld_valid && !ld_ready_o;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        ld_valid = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; err_clr = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 40));
        return {27'h0, 3'($urandom_range(0, 7)), 2'b00};
    endfunction

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        core_req = 1; core_addr = 32'h8; ld_valid = 1; ld_addr = 32'h10;
        @(negedge clk);
        n_chk++;
        if ({ld_ready_o, core_stall_o, core_rdata_o, mem_addr_o, mem_data_o, mem_write_o, mem_read_o} !== '0)
            $display("FAIL reset_comb: got rdy=%0b stall=%0b crd=%h maddr=%h mdat=%h w=%0b r=%0b want all 0",
                     ld_ready_o, core_stall_o, core_rdata_o, mem_addr_o, mem_data_o, mem_write_o, mem_read_o);
        else n_pass++;
        n_chk++;
        if ({ld_rvalid_o, ld_rdata_o, err_o} !== '0)
            $display("FAIL reset_regs: got rvalid=%0b rdata=%h err=%0b want 0", ld_rvalid_o, ld_rdata_o, err_o);
        else n_pass++;
        idle_inputs();
        rst_n = 1;
        next_cyc();
    endtask

    task automatic test_core_rw();
        core_req = 1; core_we = 1; core_addr = 32'h8; core_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_chk++;
        if ({mem_write_o, mem_read_o, core_stall_o, mem_addr_o, mem_data_o} !== {3'b100, 32'h8, 32'hDEADBEEF})
            $display("FAIL core_store: got w=%0b r=%0b stall=%0b addr=%h data=%h want w=1 addr=8 data=deadbeef",
                     mem_write_o, mem_read_o, core_stall_o, mem_addr_o, mem_data_o);
        else n_pass++;
        next_cyc();
        core_we = 0;
        @(negedge clk);
        n_chk++;
        if ({core_rdata_o, mem_read_o, core_stall_o} !== {32'hDEADBEEF, 2'b10})
            $display("FAIL core_load: got rdata=%h rd=%0b stall=%0b want deadbeef rd=1 stall=0",
                     core_rdata_o, mem_read_o, core_stall_o);
        else n_pass++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_loader_rw();
        ld_valid = 1; ld_we = 1; ld_addr = 32'h10; ld_wdata = 32'h12345678;
        @(negedge clk);
        n_chk++;
        if ({ld_ready_o, mem_write_o} !== 2'b11)
            $display("FAIL ld_write: got rdy=%0b w=%0b want 1 1", ld_ready_o, mem_write_o);
        else n_pass++;
        next_cyc();
        ld_we = 0;
        @(negedge clk);
        n_chk++;
        if ({ld_ready_o, mem_read_o} !== 2'b11)
            $display("FAIL ld_read_grant: got rdy=%0b r=%0b want 1 1", ld_ready_o, mem_read_o);
        else n_pass++;
        next_cyc();
        ld_addr = 32'h8;
        @(negedge clk);
        n_chk++;
        if ({ld_rvalid_o, ld_rdata_o, ld_ready_o} !== {1'b1, 32'h12345678, 1'b1})
            $display("FAIL ld_read_resp1: got rvalid=%0b rdata=%h rdy=%0b want 1 12345678 1",
                     ld_rvalid_o, ld_rdata_o, ld_ready_o);
        else n_pass++;
        next_cyc();
        ld_valid = 0;
        @(negedge clk);
        n_chk++;
        if ({ld_rvalid_o, ld_rdata_o} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL ld_read_resp2: got rvalid=%0b rdata=%h want 1 deadbeef", ld_rvalid_o, ld_rdata_o);
        else n_pass++;
        next_cyc();
        @(negedge clk);
        n_chk++;
        if (ld_rvalid_o !== 1'b0) $display("FAIL ld_rvalid_pulse: got %0b want 0", ld_rvalid_o);
        else n_pass++;
        next_cyc();
        idle_inputs();
    endtask

    task automatic test_starve();
        core_req = 1; core_addr = 32'h8;
        ld_valid = 1; ld_addr = 32'h10;
        for (int c = 1; c <= 10; c++) begin
            logic frc;
            frc = (c == 5) || (c == 10);
            @(negedge clk);
            n_chk++;
            if ({ld_ready_o, core_stall_o, core_rdata_o} !== {frc, frc, frc ? 32'h0 : 32'hDEADBEEF})
                $display("FAIL starve_c%0d: got rdy=%0b stall=%0b crd=%h want rdy=%0b stall=%0b",
                         c, ld_ready_o, core_stall_o, core_rdata_o, frc, frc);
            else n_pass++;
            if (c == 6) begin
                n_chk++;
                if ({ld_rvalid_o, ld_rdata_o} !== {1'b1, 32'h12345678})
                    $display("FAIL starve_resp: got rvalid=%0b rdata=%h want 1 12345678", ld_rvalid_o, ld_rdata_o);
                else n_pass++;
            end
            next_cyc();
        end
        idle_inputs();
    endtask

    task automatic test_errors();
        core_req = 1; core_we = 1; core_addr = 32'h1C; core_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        n_chk++;
        if ({mem_write_o, mem_addr_o, err_o} !== {1'b1, 32'h1C, 1'b0})
            $display("FAIL err_edge_store: got w=%0b addr=%h err=%0b want 1 1c 0", mem_write_o, mem_addr_o, err_o);
        else n_pass++;
        next_cyc();
        core_we = 0; core_addr = 32'h6;
        @(negedge clk);
        n_chk++;
        if ({mem_write_o, mem_read_o, core_stall_o, core_rdata_o} !== '0)
            $display("FAIL err_misalign: got w=%0b r=%0b stall=%0b crd=%h want all 0",
                     mem_write_o, mem_read_o, core_stall_o, core_rdata_o);
        else n_pass++;
        next_cyc();
        idle_inputs();
        ld_valid = 1; ld_we = 1; ld_addr = 32'h1E; ld_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        n_chk++;
        if ({err_o, ld_ready_o, mem_write_o, mem_read_o} !== 4'b1100)
            $display("FAIL err_range_ld: got err=%0b rdy=%0b w=%0b r=%0b want 1 1 0 0",
                     err_o, ld_ready_o, mem_write_o, mem_read_o);
        else n_pass++;
        next_cyc();
        idle_inputs();
        core_req = 1; core_addr = 32'h1C;
        @(negedge clk);
        n_chk++;
        if ({core_rdata_o, err_o} !== {32'hA5A5A5A5, 1'b1})
            $display("FAIL err_sticky: got crd=%h err=%0b want a5a5a5a5 1", core_rdata_o, err_o);
        else n_pass++;
        next_cyc();
        core_addr = 32'h20; err_clr = 1;
        @(negedge clk);
        n_chk++;
        if ({core_rdata_o, mem_read_o} !== 33'h0)
            $display("FAIL err_oob_load: got crd=%h r=%0b want 0 0", core_rdata_o, mem_read_o);
        else n_pass++;
        next_cyc();
        core_req = 0;
        @(negedge clk);
        n_chk++;
        if (err_o !== 1'b1) $display("FAIL err_set_over_clr: got %0b want 1", err_o);
        else n_pass++;
        next_cyc();
        err_clr = 0;
        @(negedge clk);
        n_chk++;
        if (err_o !== 1'b0) $display("FAIL err_clear: got %0b want 0", err_o);
        else n_pass++;
        next_cyc();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ld_valid = 1; ld_addr = 32'h10;
        next_cyc();
        ld_valid = 0;
        n_chk++;
        if (ld_rvalid_o !== 1'b1) $display("FAIL rstmid_pre_rvalid: got %0b want 1", ld_rvalid_o);
        else n_pass++;
        #1 rst_n = 0;
        #1;
        n_chk++;
        if (ld_rvalid_o !== 1'b0) $display("FAIL rstmid_rvalid_clr: got %0b want 0", ld_rvalid_o);
        else n_pass++;
        @(negedge clk) rst_n = 1;
        next_cyc();
        core_req = 1; core_addr = 32'h6; ld_valid = 1; ld_addr = 32'h10;
        repeat (3) next_cyc();
        core_addr = 32'h8;
        n_chk++;
        if ({ld_ready_o, err_o} !== 2'b01) $display("FAIL rstmid_pre: got rdy=%0b err=%0b want 0 1", ld_ready_o, err_o);
        else n_pass++;
        #1 rst_n = 0;
        #1;
        n_chk++;
        if ({ld_ready_o, core_stall_o, core_rdata_o, mem_addr_o, mem_data_o, mem_write_o, mem_read_o,
             ld_rvalid_o, err_o} !== '0)
            $display("FAIL rstmid_zero: got rdy=%0b stall=%0b crd=%h maddr=%h w=%0b r=%0b err=%0b want all 0",
                     ld_ready_o, core_stall_o, core_rdata_o, mem_addr_o, mem_write_o, mem_read_o, err_o);
        else n_pass++;
        idle_inputs();
        @(negedge clk) rst_n = 1;
        next_cyc();
        core_req = 1; core_addr = 32'h8; ld_valid = 1; ld_addr = 32'h10;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_chk++;
            if ({ld_ready_o, core_stall_o} !== {2{c == 5}})
                $display("FAIL rstmid_starve_c%0d: got rdy=%0b stall=%0b want %0b", c, ld_ready_o, core_stall_o, c == 5);
            else n_pass++;
            next_cyc();
        end
        idle_inputs();
        @(negedge clk);
        n_chk++;
        if ({ld_rvalid_o, ld_rdata_o} !== {1'b1, 32'h12345678})
            $display("FAIL rstmid_mem: got rvalid=%0b rdata=%h want 1 12345678", ld_rvalid_o, ld_rdata_o);
        else n_pass++;
        next_cyc();
    endtask

    task automatic test_random();
        int          m_starve;
        logic        m_err, m_rvalid, pend;
        logic [31:0] m_rdata;
        logic [31:0] ref_mem [8];
        logic        forced, e_rdy, e_cg, any, gwe, glegal;
        logic [31:0] gaddr, gwd, e_crd;
        logic [99:0] exp_c, got_c;
        idle_inputs();
        rst_n = 0;
        @(negedge clk) rst_n = 1;
        next_cyc();
        m_starve = 0; m_err = 0; m_rvalid = 0; m_rdata = 0; pend = 0;
        for (int i = 0; i < 600; i++) begin
            if (i < 8) begin
                core_req = 0; err_clr = 0;
                ld_valid = 1; ld_we = 1; ld_addr = 32'(i * 4); ld_wdata = $urandom; pend = 1;
            end else begin
                core_req = ($urandom_range(0, 9) < 6);
                core_we = 1'($urandom_range(0, 1)); core_addr = pick_addr(); core_wdata = $urandom;
                if (!pend && $urandom_range(0, 1) == 1) begin
                    pend = 1; ld_we = 1'($urandom_range(0, 1)); ld_addr = pick_addr(); ld_wdata = $urandom;
                end
                ld_valid = pend;
                err_clr = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            forced = ld_valid && (m_starve == STARVE_MAX);
            e_rdy  = ld_valid && (forced || !core_req);
            e_cg   = core_req && !forced;
            any    = e_rdy || e_cg;
            gwe    = e_rdy ? ld_we : core_we;
            gaddr  = e_rdy ? ld_addr : core_addr;
            gwd    = e_rdy ? ld_wdata : core_wdata;
            glegal = (gaddr[1:0] == 2'b00) && (gaddr < LIM);
            e_crd  = (e_cg && glegal && !core_we) ? ref_mem[gaddr[ADDR_W-1:2]] : 32'h0;
            exp_c  = {e_rdy, core_req && forced, any && glegal && gwe, any && glegal && !gwe,
                      (any && glegal) ? gaddr : 32'h0, (any && glegal) ? gwd : 32'h0, e_crd};
            got_c  = {ld_ready_o, core_stall_o, mem_write_o, mem_read_o, mem_addr_o, mem_data_o, core_rdata_o};
            n_chk++;
            if (got_c !== exp_c) $display("FAIL rand_comb cyc %0d: got %h want %h", i, got_c, exp_c);
            else n_pass++;
            n_chk++;
            if ({ld_rvalid_o, err_o} !== {m_rvalid, m_err} || (m_rvalid && ld_rdata_o !== m_rdata))
                $display("FAIL rand_regs cyc %0d: got rvalid=%0b rdata=%h err=%0b want %0b %h %0b",
                         i, ld_rvalid_o, ld_rdata_o, err_o, m_rvalid, m_rdata, m_err);
            else n_pass++;
            @(posedge clk);
            m_rvalid = e_rdy && !ld_we;
            if (m_rvalid) m_rdata = glegal ? ref_mem[gaddr[ADDR_W-1:2]] : 32'h0;
            if (any && glegal && gwe) ref_mem[gaddr[ADDR_W-1:2]] = gwd;
            if (any && !glegal) m_err = 1;
            else if (err_clr) m_err = 0;
            if (!ld_valid || e_rdy) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
            if (e_rdy) pend = 0;
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_core_rw();
        test_loader_rw();
        test_starve();
        test_errors();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
